// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared address map, sizes and stop-FSM encodings
package mem_io_responder_pkg;
  localparam int RAM_AW = 17;
  localparam int TXF_AW = 3;
  localparam logic [31:0] IO_BASE_ADDR = 32'h30000;
  localparam logic [15:0] IO_UART_OFS = 16'h0000;
  localparam logic [15:0] IO_CLK_OFS = 16'h0004;
  localparam int RAM_BYTES = 1 << RAM_AW;
  typedef enum logic [1:0] {ST_RUN, ST_STOP_PEND, ST_DONE} stop_st_t;
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    return w[8*k +: 8];
  endfunction
endpackage

// File: rtl/mem_io_responder_ram_byte_sp.sv
// ram_byte_sp: single-port byte RAM with synchronous write and registered read
module ram_byte_sp #(
  parameter int AW = 17
) (
  input  logic          clk_in,
  input  logic          rst_in_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];
  // array write kept reset-free so it maps onto block RAM
  always_ff @(posedge clk_in)
    if (we) mem[addr] <= wdata;
  // registered read port, holds between reads
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: RAM, UART RX/TX FIFO, cycle counter and program-stop behind the core byte bus
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int          RAM_ADDR_W  = RAM_AW,
  parameter int          TXF_DEPTH_W = TXF_AW,
  parameter logic [31:0] IO_BASE     = IO_BASE_ADDR
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_done
);
  localparam logic [TXF_DEPTH_W:0] DEPTH = (TXF_DEPTH_W+1)'(1 << TXF_DEPTH_W);
  localparam logic [TXF_DEPTH_W:0] ALMOST = DEPTH - (TXF_DEPTH_W+1)'(2);
  logic unused_a;
  assign unused_a = ^mem_a[31:18];
  logic is_io, is_ram, rd, wr, uart_sel, clk_sel, clk_wr;
  logic [15:0] ofs;
  logic [7:0] ram_q, io_byte, io_q;
  logic src_ram;
  logic [31:0] cyc_cnt, snap;
  logic [7:0] fifo [2**TXF_DEPTH_W];
  logic [TXF_DEPTH_W-1:0] wp, rp;
  logic [TXF_DEPTH_W:0] cnt;
  logic full, pop, push_req, push, tx_ovf, run;
  logic [7:0] push_data;
  stop_st_t state, state_nx;
  assign ofs = mem_a[15:0];
  assign is_io = mem_a[17:16] == IO_BASE[17:16];
  assign is_ram = !mem_a[17];
  assign rd = rdy_in && !mem_wr;
  assign wr = rdy_in && mem_wr;
  assign uart_sel = is_io && ofs == IO_UART_OFS;
  assign clk_sel = is_io && ofs[15:2] == IO_CLK_OFS[15:2];
  assign clk_wr = wr && is_io && ofs == IO_CLK_OFS;
  ram_byte_sp #(.AW(RAM_ADDR_W)) u_ram (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .we      (wr && is_ram),
    .re      (rd && is_ram),
    .addr    (mem_a[RAM_ADDR_W-1:0]),
    .wdata   (mem_dout),
    .rdata   (ram_q)
  );
  // I/O read byte; the snapshot low byte comes straight from the counter as it is loaded
  always_comb begin
    io_byte = !is_io ? 8'h00 :
              uart_sel ? (rx_valid ? rx_data : 8'h00) :
              !clk_sel ? 8'h00 :
              mem_a[1:0] == 2'd0 ? cyc_cnt[7:0] : byte_sel(snap, mem_a[1:0]);
    rx_pop = rd && uart_sel && rx_valid;
  end
  // read-side registers: source select and I/O byte delayed to line up with the RAM output
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      src_ram <= 1'b0;
      io_q <= '0;
      snap <= '0;
    end else if (rd) begin
      src_ram <= is_ram;
      io_q <= io_byte;
      if (clk_sel && mem_a[1:0] == 2'd0) snap <= cyc_cnt;
    end
  assign mem_din = src_ram ? ram_q : io_q;
  // free-running cycle counter
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) cyc_cnt <= '0;
    else cyc_cnt <= cyc_cnt + 32'd1;
  // TX push: non-zero UART bytes, or the stop marker 0x00, only while still running
  always_comb begin
    full = cnt == DEPTH;
    pop = tx_valid && tx_ready;
    push_req = run && (clk_wr || (wr && uart_sel && mem_dout != 8'h00));
    push_data = clk_wr ? 8'h00 : mem_dout;
    push = push_req && (!full || pop);
  end
  // FIFO storage kept reset-free
  always_ff @(posedge clk_in)
    if (push) fifo[wp] <= push_data;
  // FIFO pointers, occupancy, overflow flag and registered almost-full
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      tx_ovf <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (TXF_DEPTH_W+1)'(push) - (TXF_DEPTH_W+1)'(pop);
      if (push_req && !push) tx_ovf <= 1'b1;
      io_buffer_full <= cnt >= ALMOST;
    end
  assign tx_valid = cnt != '0;
  assign tx_data = fifo[rp];
  // stop FSM state register
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) state <= ST_RUN;
    else state <= state_nx;
  // stop FSM next state; the stop marker is the only 0x00 that can reach the FIFO
  always_comb
    state_nx = (state == ST_RUN && clk_wr && push) ? ST_STOP_PEND :
               (state == ST_STOP_PEND && pop && tx_data == 8'h00) ? ST_DONE : state;
  // stop FSM outputs
  always_comb begin
    run = state == ST_RUN;
    prog_done = state == ST_DONE;
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed checks of RAM, hole, UART RX/TX, counter snapshot and stop
module tb_mem_io_responder;
  logic clk_in = 0, rst_in_n = 0, rdy_in = 0, mem_wr = 0;
  logic [31:0] mem_a = 0;
  logic [7:0] mem_dout = 0, mem_din, rx_data = 0, tx_data;
  logic io_buffer_full, rx_valid = 0, rx_pop, tx_valid, tx_ready = 0, prog_done;
  int n_chk = 0, n_bad = 0;
  logic [7:0] txq [$];
  mem_io_responder dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .prog_done(prog_done)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) if (tx_valid && tx_ready) txq.push_back(tx_data);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [31:0] a, input logic [7:0] d);
    rdy_in = 1; mem_wr = w; mem_a = a; mem_dout = d;
    @(negedge clk_in);
    rdy_in = 0; mem_wr = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk_in);
    chk("rst_din", mem_din, 0);
    chk("rst_pop", rx_pop, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_ibf", io_buffer_full, 0);
    chk("rst_done", prog_done, 0);
    rst_in_n = 1;
    // RAM and hole
    bus(1, 32'h00123, 8'hA5);
    bus(0, 32'h00123, 0);
    chk("ram_rd", mem_din, 8'hA5);
    bus(1, 32'h20010, 8'h55);
    bus(0, 32'h20010, 0);
    chk("hole_rd", mem_din, 8'h00);
    // rdy_in low blocks writes and pushes
    bus(1, 32'h00010, 8'h11);
    bus(0, 32'h00010, 0);
    chk("ram_rd2", mem_din, 8'h11);
    mem_wr = 1; mem_a = 32'h00010; mem_dout = 8'h77;
    @(negedge clk_in);
    chk("rdy0_hold", mem_din, 8'h11);
    mem_a = 32'h30000; mem_dout = 8'h55;
    @(negedge clk_in);
    mem_wr = 0;
    chk("rdy0_nopush", tx_valid, 0);
    bus(0, 32'h00010, 0);
    chk("rdy0_ram", mem_din, 8'h11);
    // UART RX
    rx_valid = 1; rx_data = 8'h5A;
    rdy_in = 1; mem_wr = 0; mem_a = 32'h30000;
    #1 chk("rx_pop1", rx_pop, 1);
    @(negedge clk_in);
    rdy_in = 0; rx_valid = 0;
    chk("rx_data", mem_din, 8'h5A);
    rdy_in = 1;
    #1 chk("rx_pop0", rx_pop, 0);
    @(negedge clk_in);
    rdy_in = 0;
    chk("rx_empty", mem_din, 8'h00);
    // TX with zero filter
    tx_ready = 1; txq.delete();
    bus(1, 32'h30000, 8'h48);
    bus(1, 32'h30000, 8'h69);
    bus(1, 32'h30000, 8'h00);
    repeat (3) @(negedge clk_in);
    chk("tx_n", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("tx_0", txq[0], 8'h48);
      chk("tx_1", txq[1], 8'h69);
    end
    // fill, almost-full, overflow, drain order
    tx_ready = 0; txq.delete();
    for (int i = 0; i < 8; i++) begin
      bus(1, 32'h30000, 8'(8'h10 + i));
      if (i == 5) chk("ibf_at6", io_buffer_full, 0);
      if (i == 6) chk("ibf_at7", io_buffer_full, 1);
      if (i == 7) chk("ovf0", dut.tx_ovf, 0);
    end
    bus(1, 32'h30000, 8'h99);
    chk("ovf1", dut.tx_ovf, 1);
    chk("cnt_full", dut.cnt, 8);
    tx_ready = 1;
    repeat (10) @(negedge clk_in);
    chk("drain_n", txq.size(), 8);
    for (int i = 0; i < 8 && i < txq.size(); i++) chk($sformatf("drain_%0d", i), txq[i], 8'(8'h10 + i));
    chk("ibf_empty", io_buffer_full, 0);
    // counter snapshot across the wrap
    force dut.cyc_cnt = 32'hFFFFFFFE;
    #1 release dut.cyc_cnt;
    bus(0, 32'h30004, 0);
    chk("snap0", mem_din, 8'hFE);
    bus(0, 32'h30005, 0);
    chk("snap1", mem_din, 8'hFF);
    bus(0, 32'h30006, 0);
    chk("snap2", mem_din, 8'hFF);
    bus(0, 32'h30007, 0);
    chk("snap3", mem_din, 8'hFF);
    chk("cnt_wrap", dut.cyc_cnt, 32'h2);
    bus(0, 32'h30008, 0);
    chk("io_other", mem_din, 8'h00);
    // program stop
    tx_ready = 0; txq.delete();
    bus(1, 32'h30000, 8'h41);
    bus(1, 32'h30004, 8'h00);
    bus(1, 32'h30000, 8'h42);
    chk("stop_cnt", dut.cnt, 2);
    chk("stop_pend", prog_done, 0);
    tx_ready = 1;
    @(negedge clk_in);
    chk("done_early", prog_done, 0);
    @(negedge clk_in);
    chk("done", prog_done, 1);
    chk("stop_n", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("stop_0", txq[0], 8'h41);
      chk("stop_1", txq[1], 8'h00);
    end
    bus(1, 32'h30000, 8'h43);
    chk("after_stop", tx_valid, 0);
    chk("done_sticky", prog_done, 1);
    // asynchronous reset mid-cycle
    #2 rst_in_n = 0;
    #1 chk("rst_done2", prog_done, 0);
    chk("rst_cnt", dut.cyc_cnt, 0);
    @(negedge clk_in);
    rst_in_n = 1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
